// File: rtl/ser_tx_sched.sv
// Round-robin share of the serial transmitter between two word requesters.
// Grant and start strobe one cycle after request; MSB-first bits follow, then wait for the valid window.
module ser_tx_sched #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] data0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              in_pulse,
   output logic              ser_in,
   input  logic              ser_out_valid,
   output logic              busy,
   output logic              grant_id,
   output logic [3:0]        frame_cnt,
   output logic              timeout_err
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT_V, WAIT_D} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic [15:0]       tmr_q, tmr_d;
   logic              last_q, last_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              in_pulse_q, in_pulse_d;
   logic              ser_in_q, ser_in_d;
   logic              busy_q, busy_d;
   logic              grant_id_q, grant_id_d;
   logic [3:0]        frame_cnt_q, frame_cnt_d;
   logic              terr_q, terr_d;
   logic              sel;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      last_d      = last_q;
      grant_id_d  = grant_id_q;
      frame_cnt_d = frame_cnt_q;
      terr_d      = terr_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      in_pulse_d  = 1'b0;
      ser_in_d    = 1'b0;
      sel         = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the requester not served last time wins.
               sel        = (req0 && req1) ? ~last_q : req1;
               shift_d    = sel ? data1 : data0;
               grant_id_d = sel;
               last_d     = sel;
               gnt0_d     = ~sel;
               gnt1_d     = sel;
               in_pulse_d = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            ser_in_d = shift_q[DATA_W-1];
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d    = '0;
            state_d  = SHIFT;
         end
         SHIFT: begin
            if (cnt_q == BW'(DATA_W - 1)) begin
               tmr_d   = '0;
               state_d = WAIT_V;
            end else begin
               ser_in_d = shift_q[DATA_W-1];
               shift_d  = {shift_q[DATA_W-2:0], 1'b0};
               cnt_d    = cnt_q + BW'(1);
            end
         end
         WAIT_V: begin
            tmr_d = tmr_q + 16'd1;
            if (ser_out_valid) begin
               state_d = WAIT_D;
            end else if (tmr_q == 16'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_D: begin
            tmr_d = tmr_q + 16'd1;
            if (!ser_out_valid) begin
               frame_cnt_d = frame_cnt_q + 4'd1;
               state_d     = IDLE;
            end else if (tmr_q == 16'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         in_pulse_q  <= 1'b0;
         ser_in_q    <= 1'b0;
         busy_q      <= 1'b0;
         grant_id_q  <= 1'b0;
         frame_cnt_q <= 4'd0;
         terr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         in_pulse_q  <= in_pulse_d;
         ser_in_q    <= ser_in_d;
         busy_q      <= busy_d;
         grant_id_q  <= grant_id_d;
         frame_cnt_q <= frame_cnt_d;
         terr_q      <= terr_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign in_pulse    = in_pulse_q;
   assign ser_in      = ser_in_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;
   assign frame_cnt   = frame_cnt_q;
   assign timeout_err = terr_q;
endmodule

// File: tb/tb_ser_tx_sched.sv
// Directed bench for ser_tx_sched: bit sequencing, round-robin, timeout, async reset, count wrap.
module tb_ser_tx_sched;
   logic       clk;
   logic       rst;
   logic       req0, req1;
   logic [7:0] data0, data1;
   logic       gnt0, gnt1, in_pulse, ser_in, ser_out_valid;
   logic       busy, grant_id, timeout_err;
   logic [3:0] frame_cnt;

   int         checks = 0;
   int         errors = 0;
   int         gnt1_seen = 0;
   logic [3:0] exp_cnt = 4'd0;

   ser_tx_sched #(.DATA_W(8), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .in_pulse(in_pulse), .ser_in(ser_in),
      .ser_out_valid(ser_out_valid), .busy(busy), .grant_id(grant_id),
      .frame_cnt(frame_cnt), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (rst && gnt1) gnt1_seen++;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Grant, start strobe, 8 data bits, then returns on the first WAIT_V cycle.
   task automatic send_bits(input logic id, input logic [7:0] data, input bit drop);
      step();
      chk("gnt0", {31'd0, gnt0}, {31'd0, ~id});
      chk("gnt1", {31'd0, gnt1}, {31'd0, id});
      chk("in_pulse_start", {31'd0, in_pulse}, 32'd1);
      chk("ser_in_start", {31'd0, ser_in}, 32'd0);
      chk("busy_start", {31'd0, busy}, 32'd1);
      chk("grant_id", {31'd0, grant_id}, {31'd0, id});
      if (drop) begin
         if (id) begin req1 = 1'b0; data1 = 8'h00; end
         else    begin req0 = 1'b0; data0 = 8'h00; end
      end
      for (int i = 7; i >= 0; i--) begin
         step();
         chk("ser_in_bit", {31'd0, ser_in}, {31'd0, data[i]});
         if (i == 7) begin
            chk("in_pulse_bit0", {31'd0, in_pulse}, 32'd0);
            chk("gnt_pulse_len", {30'd0, gnt1, gnt0}, 32'd0);
         end
      end
      step();
      chk("ser_in_waitv", {31'd0, ser_in}, 32'd0);
      chk("busy_waitv", {31'd0, busy}, 32'd1);
   endtask

   task automatic finish_frame(input logic id, input int vdelay, input int vlen);
      repeat (vdelay) step();
      ser_out_valid = 1'b1;
      repeat (vlen) step();
      chk("busy_in_valid", {31'd0, busy}, 32'd1);
      ser_out_valid = 1'b0;
      step();
      exp_cnt = exp_cnt + 4'd1;
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("frame_cnt", {28'd0, frame_cnt}, {28'd0, exp_cnt});
      chk("grant_id_hold", {31'd0, grant_id}, {31'd0, id});
   endtask

   task automatic do_frame(input logic id, input logic [7:0] data, input int vdelay,
                           input int vlen, input bit drop);
      send_bits(id, data, drop);
      finish_frame(id, vdelay, vlen);
   endtask

   initial begin
      int base;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
      ser_out_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {24'd0, gnt0, gnt1, in_pulse, ser_in, busy, grant_id, timeout_err, 1'b0}, 32'd0);
      chk("rst_frame_cnt", {28'd0, frame_cnt}, 32'd0);
      rst = 1'b1;

      // Single frame from requester 0; word is latched at grant.
      req0 = 1'b1; data0 = 8'hA5;
      do_frame(1'b0, 8'hA5, 2, 3, 1'b1);

      // Transmitter never responds: abort after exactly 255 cycles.
      req0 = 1'b1; data0 = 8'h3C;
      send_bits(1'b0, 8'h3C, 1'b1);
      chk("terr_entry", {31'd0, timeout_err}, 32'd0);
      repeat (254) step();
      chk("terr_254", {31'd0, timeout_err}, 32'd0);
      chk("busy_254", {31'd0, busy}, 32'd1);
      step();
      chk("terr_255", {31'd0, timeout_err}, 32'd1);
      chk("busy_timeout", {31'd0, busy}, 32'd0);
      chk("cnt_timeout", {28'd0, frame_cnt}, {28'd0, exp_cnt});
      req1 = 1'b1; data1 = 8'hC3;
      do_frame(1'b1, 8'hC3, 0, 1, 1'b1);
      chk("terr_sticky", {31'd0, timeout_err}, 32'd1);

      // Asynchronous reset during bit 4 of the shift phase.
      req0 = 1'b1; data0 = 8'hF0;
      step();
      chk("gnt0_pre_rst", {31'd0, gnt0}, 32'd1);
      req0 = 1'b0;
      repeat (4) step();
      chk("ser_in_bit4", {31'd0, ser_in}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_outs", {24'd0, gnt0, gnt1, in_pulse, ser_in, busy, grant_id, timeout_err, 1'b0}, 32'd0);
      chk("arst_cnt", {28'd0, frame_cnt}, 32'd0);
      exp_cnt = 4'd0;
      rst = 1'b1;
      req1 = 1'b1; data1 = 8'h5A;
      do_frame(1'b1, 8'h5A, 1, 2, 1'b1);

      // Fresh reset, then both requesters held: order 0,1,0,1.
      rst = 1'b0;
      step();
      rst = 1'b1;
      exp_cnt = 4'd0;
      chk("rst2_cnt", {28'd0, frame_cnt}, 32'd0);
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h80;
      do_frame(1'b0, 8'h01, 1, 1, 1'b0);
      do_frame(1'b1, 8'h80, 1, 1, 1'b0);
      do_frame(1'b0, 8'h01, 1, 1, 1'b0);
      do_frame(1'b1, 8'h80, 1, 1, 1'b0);
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_cnt4", {28'd0, frame_cnt}, 32'd4);
      step();
      chk("rr_idle_busy", {31'd0, busy}, 32'd0);

      // req1 pulses during a req0 frame and is gone before IDLE.
      req0 = 1'b1; data0 = 8'h96;
      send_bits(1'b0, 8'h96, 1'b1);
      req1 = 1'b1; data1 = 8'h77;
      step();
      chk("drop_gnt1_a", {31'd0, gnt1}, 32'd0);
      ser_out_valid = 1'b1;
      step();
      chk("drop_busy", {31'd0, busy}, 32'd1);
      req1 = 1'b0;
      ser_out_valid = 1'b0;
      step();
      exp_cnt = exp_cnt + 4'd1;
      chk("drop_busy_done", {31'd0, busy}, 32'd0);
      chk("drop_cnt", {28'd0, frame_cnt}, 32'd5);
      step();
      chk("drop_gnt1_b", {31'd0, gnt1}, 32'd0);
      chk("drop_idle", {31'd0, busy}, 32'd0);

      // 16 back-to-back frames from requester 1; count wraps through 0.
      base = gnt1_seen;
      req1 = 1'b1; data1 = 8'hC9;
      for (int k = 0; k < 16; k++) begin
         do_frame(1'b1, 8'hC9, 0, 2, 1'b0);
         if (k == 10) chk("cnt_wrap", {28'd0, frame_cnt}, 32'd0);
      end
      req1 = 1'b0;
      step();
      chk("gnt1_count", gnt1_seen - base, 32'd16);
      chk("cnt_final", {28'd0, frame_cnt}, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ser_tx_sched.md
Name: ser_tx_sched

Overview:
- Round-robin scheduler that shares the serial transmitter datapath between two parallel-word requesters.
- Grants one requester and latches its word.
- Sequences the transmitter's start pulse and serial input bit stream, then waits for the transmitter's output-valid window to finish.
- Sits between requesters and the transmitter; also produces a 4-bit completed-frame count for the seven-segment display.

Parameters:
- DATA_W, 8: payload bits per frame shifted into the transmitter.
- TIMEOUT, 255: max cycles spent waiting for the transmitter's ser_out_valid window before abort. Must be ≥1 and < 2^16.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 has a word pending; held until gnt0
- data0  input  DATA_W  requester 0 word; stable while req0 high
- req1  input  1  requester 1 has a word pending
- data1  input  DATA_W  requester 1 word
- gnt0  output  1  one-cycle pulse: data0 captured
- gnt1  output  1  one-cycle pulse: data1 captured
- in_pulse  output  1  start strobe to transmitter
- ser_in  output  1  serial data to transmitter, MSB first
- ser_out_valid  input  1  transmitter output-valid indication
- busy  output  1  high in every state except IDLE
- grant_id  output  1  source of the frame in flight (0/1); holds last value in IDLE
- frame_cnt  output  4  completed frames, wraps 15→0; drives display
- timeout_err  output  1  sticky abort flag

Behaviour:
- All outputs are registered (Moore).
- Reset (rst=0, async) values:
  - gnt0=gnt1=in_pulse=ser_in=busy=grant_id=timeout_err=0; frame_cnt=0.
  - State=IDLE; RR pointer last=1, so requester 0 wins the first tie.
  - Reset mid-frame aborts immediately; no partial count.
- States: IDLE, START, SHIFT, WAIT_V, WAIT_D.
- IDLE:
  - If exactly one req is high, select it. If both are high, select the requester not equal to last.
  - At the edge: shift_reg<=data_sel, grant_id<=sel, last<=sel, gnt_sel<=1 for exactly one cycle, state<=START.
  - No req: remain in IDLE, outputs idle.
- START (1 cycle): in_pulse=1, ser_in=0, then SHIFT.
- SHIFT (DATA_W cycles): ser_in=shift_reg[DATA_W-1] each cycle, shift left by one; in_pulse=0. After the last bit, go to WAIT_V; ser_in returns to 0.
- WAIT_V: wait for ser_out_valid=1, then WAIT_D.
- WAIT_D: wait for ser_out_valid=0. Then frame_cnt<=frame_cnt+1 (mod 16) and go to IDLE.
- Timeout:
  - A single counter clears on entry to WAIT_V and runs through WAIT_V and WAIT_D.
  - When it reaches TIMEOUT: timeout_err<=1 (sticky until reset), go to IDLE, frame_cnt unchanged.
- Latency: req high in IDLE at cycle N → gnt at N+1, in_pulse at N+1, first data bit at N+2, last data bit at N+1+DATA_W.
- ser_out_valid already high on entry to WAIT_V: passes to WAIT_D next cycle.
- Requests arriving while busy are ignored until return to IDLE; no queuing. Back-to-back frames have one IDLE cycle between them.
- A req dropped before grant is never granted. data change after gnt has no effect.
- frame_cnt wrap: 15 + 1 → 0, with no flag.

Test Plan:
- Reset then req0=1, data0=8'hA5, transmitter model pulses ser_out_valid for 3 cycles after 2-cycle delay → gnt0 one cycle, in_pulse one cycle, ser_in=1,0,1,0,0,1,0,1, frame_cnt=1, busy low after valid falls.
- req0 and req1 both held high continuously with data 8'h01/8'h80 → grant order 0,1,0,1; grant_id alternates; frame_cnt=4 after 4 frames.
- Transmitter model never asserts ser_out_valid, TIMEOUT=255 → timeout_err=1 exactly 255 cycles after WAIT_V entry; frame_cnt unchanged; next req still served.
- Assert rst=0 during SHIFT bit 4 → all outputs 0 asynchronously; after release, req1 alone is granted first and sent cleanly.
- 16 back-to-back frames from req1 → frame_cnt wraps 15→0; gnt1 count = 16.
- req1 asserted during a req0 frame and dropped before IDLE → no gnt1; busy deasserts; frame_cnt +1 only.
